// File: rtl/btb_assoc.sv
// Set-associative branch target buffer.
// Lookup on the IF-stage PC is combinational; training from the EX stage lands at the
// posedge, so a same-cycle lookup sees the pre-update table.
// Each set replaces round-robin once all of its ways are valid.
module btb_assoc #(
    parameter int XLEN     = 32,
    parameter int SETS     = 16,
    parameter int WAYS     = 2,
    parameter int CNT_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] target_pc,
    output logic            valid,
    output logic            predicted_taken,
    input  logic            update,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    input  logic            flush_all
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    // A one-way table still gets a 1-bit pointer so the array types stay legal; it never moves.
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

    logic                v_q   [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_q [SETS][WAYS];
    logic [XLEN-1:0]     tgt_q [SETS][WAYS];
    logic [CNT_BITS-1:0] cnt_q [SETS][WAYS];
    logic [WAY_BITS-1:0] rr_q  [SETS];

    logic [IDX_BITS-1:0] lidx, uidx;
    logic [TAG_BITS-1:0] ltag, utag;
    logic                upd_hit, has_inv;
    logic [WAY_BITS-1:0] hit_way, inv_way, victim;
    logic                unused_lsbs;

    assign lidx = pc[IDX_BITS+1:2];
    assign ltag = pc[XLEN-1:IDX_BITS+2];
    assign uidx = update_pc[IDX_BITS+1:2];
    assign utag = update_pc[XLEN-1:IDX_BITS+2];
    assign unused_lsbs = ^{pc[1:0], update_pc[1:0]};

    // Lookup: scan high to low so the lowest matching way ends up winning.
    always_comb begin
        valid           = 1'b0;
        target_pc       = '0;
        predicted_taken = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v_q[lidx][w] && (tag_q[lidx][w] == ltag)) begin
                valid           = 1'b1;
                target_pc       = tgt_q[lidx][w];
                predicted_taken = cnt_q[lidx][w][CNT_BITS-1];
            end
        end
    end

    // Update side: find the matching way, the lowest invalid way, and the allocation victim.
    always_comb begin
        upd_hit = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v_q[uidx][w] && (tag_q[uidx][w] == utag)) begin
                upd_hit = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!v_q[uidx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
        victim = has_inv ? inv_way : rr_q[uidx];
    end

    // Table state: reset beats flush, flush beats training; a dropped update leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    v_q[s][w]   <= 1'b0;
                    cnt_q[s][w] <= '0;
                end
                rr_q[s] <= '0;
            end
        end else if (flush_all) begin
            // Counters are left stale; allocation always reinitialises them.
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    v_q[s][w] <= 1'b0;
                end
                rr_q[s] <= '0;
            end
        end else if (update) begin
            if (upd_hit) begin
                if (update_taken) begin
                    tgt_q[uidx][hit_way] <= update_target;
                    if (cnt_q[uidx][hit_way] != CNT_MAX) begin
                        cnt_q[uidx][hit_way] <= cnt_q[uidx][hit_way] + 1'b1;
                    end
                end else if (cnt_q[uidx][hit_way] != '0) begin
                    cnt_q[uidx][hit_way] <= cnt_q[uidx][hit_way] - 1'b1;
                end
            end else if (update_taken) begin
                v_q[uidx][victim]   <= 1'b1;
                tag_q[uidx][victim] <= utag;
                tgt_q[uidx][victim] <= update_target;
                cnt_q[uidx][victim] <= CNT_WEAK;
                if (!has_inv && (WAYS > 1)) begin
                    rr_q[uidx] <= rr_q[uidx] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (XLEN=32, SETS=16, WAYS=2, CNT_BITS=2).
// Addresses 0x100/0x140/0x180/0x1C0/0x200/0x300/0x400/0x800 all map to set 0.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] target_pc;
    logic        valid;
    logic        predicted_taken;
    logic        update;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        flush_all;

    int n_chk  = 0;
    int n_fail = 0;

    btb_assoc #(.XLEN(32), .SETS(16), .WAYS(2), .CNT_BITS(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .target_pc       (target_pc),
        .valid           (valid),
        .predicted_taken (predicted_taken),
        .update          (update),
        .update_pc       (update_pc),
        .update_target   (update_target),
        .update_taken    (update_taken),
        .flush_all       (flush_all)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a lookup PC and check all three outputs before the next edge.
    task automatic look(input string tag, input logic [31:0] a, input logic ev,
                        input logic [31:0] et, input logic ep);
        pc = a;
        #1;
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
        chk({tag, ".target"}, target_pc, et);
        chk({tag, ".taken"}, {31'd0, predicted_taken}, {31'd0, ep});
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
        update        = 1'b1;
        update_pc     = a;
        update_target = t;
        update_taken  = tk;
        tick();
        update = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = '0; update = 1'b0; update_pc = '0;
        update_target = '0; update_taken = 1'b0; flush_all = 1'b0;
        tick();
        rst = 1'b0;

        // After reset
        look("rst_100", 32'h100, 1'b0, 32'h0, 1'b0);
        look("rst_abc", 32'hABC, 1'b0, 32'h0, 1'b0);

        // Allocate weakly taken
        upd(32'h100, 32'h200, 1'b1);
        look("alloc_100", 32'h100, 1'b1, 32'h200, 1'b1);

        // Not-taken decrements, target kept
        upd(32'h100, 32'h999, 1'b0);                          // 10 -> 01
        look("nt1", 32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 32'h999, 1'b0);                          // 01 -> 00
        upd(32'h100, 32'h999, 1'b0);                          // stays 00
        upd(32'h100, 32'h200, 1'b1);                          // 00 -> 01
        look("sat_lo", 32'h100, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 32'h204, 1'b1);                          // 01 -> 10
        upd(32'h100, 32'h208, 1'b1);                          // 10 -> 11
        upd(32'h100, 32'h20C, 1'b1);                          // stays 11
        look("sat_hi_tgt", 32'h100, 1'b1, 32'h20C, 1'b1);
        upd(32'h100, 32'h0, 1'b0);                            // 11 -> 10
        look("sat_hi_nt1", 32'h100, 1'b1, 32'h20C, 1'b1);
        upd(32'h100, 32'h0, 1'b0);                            // 10 -> 01
        look("sat_hi_nt2", 32'h100, 1'b1, 32'h20C, 1'b0);

        // Not-taken miss does not allocate
        upd(32'h140, 32'h777, 1'b0);
        look("nt_miss", 32'h140, 1'b0, 32'h0, 1'b0);

        // Fresh table for replacement tests
        rst = 1'b1; tick(); rst = 1'b0;
        look("rst2_100", 32'h100, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 32'h1000, 1'b1);                         // way0
        upd(32'h140, 32'h1400, 1'b1);                         // way1, rr=0
        look("two_100", 32'h100, 1'b1, 32'h1000, 1'b1);
        look("two_140", 32'h140, 1'b1, 32'h1400, 1'b1);
        upd(32'h104, 32'h1040, 1'b1);                         // set 1, independent
        look("set1_104", 32'h104, 1'b1, 32'h1040, 1'b1);
        upd(32'h180, 32'h1800, 1'b1);                         // evicts way0, rr=1
        look("ev1_100", 32'h100, 1'b0, 32'h0, 1'b0);
        look("ev1_140", 32'h140, 1'b1, 32'h1400, 1'b1);
        look("ev1_180", 32'h180, 1'b1, 32'h1800, 1'b1);
        upd(32'h1C0, 32'h1C00, 1'b1);                         // evicts way1, rr=0
        look("ev2_140", 32'h140, 1'b0, 32'h0, 1'b0);
        look("ev2_180", 32'h180, 1'b1, 32'h1800, 1'b1);
        look("ev2_1C0", 32'h1C0, 1'b1, 32'h1C00, 1'b1);
        look("ev2_104", 32'h104, 1'b1, 32'h1040, 1'b1);
        upd(32'h200, 32'h2000, 1'b1);                         // evicts way0, rr=1

        // Flush wins over a concurrent update
        flush_all = 1'b1;
        upd(32'h300, 32'h3000, 1'b1);
        flush_all = 1'b0;
        look("fl_300", 32'h300, 1'b0, 32'h0, 1'b0);
        look("fl_1C0", 32'h1C0, 1'b0, 32'h0, 1'b0);
        look("fl_104", 32'h104, 1'b0, 32'h0, 1'b0);

        // rr cleared by flush: third allocation takes way0
        upd(32'h100, 32'h1001, 1'b1);
        upd(32'h140, 32'h1401, 1'b1);
        upd(32'h180, 32'h1801, 1'b1);                         // evicts 0x100, rr=1
        look("rr_100", 32'h100, 1'b0, 32'h0, 1'b0);
        look("rr_140", 32'h140, 1'b1, 32'h1401, 1'b1);

        // Same-cycle lookup sees the old table
        update = 1'b1; update_pc = 32'h400; update_target = 32'h500; update_taken = 1'b1;
        look("byp_pre", 32'h400, 1'b0, 32'h0, 1'b0);
        tick();
        update = 1'b0;
        look("byp_post", 32'h400, 1'b1, 32'h500, 1'b1);        // evicted way1, rr=0
        look("byp_140", 32'h140, 1'b0, 32'h0, 1'b0);
        update = 1'b1; update_pc = 32'h400; update_target = 32'h600; update_taken = 1'b1;
        look("hit_pre", 32'h400, 1'b1, 32'h500, 1'b1);
        tick();
        update = 1'b0;
        look("hit_post", 32'h400, 1'b1, 32'h600, 1'b1);

        // Reset drops a concurrent update
        rst = 1'b1;
        upd(32'h800, 32'h8000, 1'b1);
        rst = 1'b0;
        look("rstupd_800", 32'h800, 1'b0, 32'h0, 1'b0);
        look("rstupd_400", 32'h400, 1'b0, 32'h0, 1'b0);
        upd(32'h800, 32'h8000, 1'b1);
        look("after_rst", 32'h800, 1'b1, 32'h8000, 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
